// File: rtl/uart_host_link.sv
// UART host link: sends one byte under RTS/CTS handshake, then waits for and checks the
// responder's echo, reporting match, framing error or timeout with a one-cycle pulse.
`timescale 1ns / 1ps

module uart_host_link #(
   parameter int unsigned CLKS_PER_BIT   = 434,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req_data,
   input  logic       req_valid,
   output logic       req_ready,
   output logic       rts,
   input  logic       cts,
   output logic       tx,
   input  logic       rx,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_match,
   output logic       rsp_timeout,
   output logic       rsp_frame_err
);

   localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HalfLast = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [23:0] TmoLast  = 24'(TIMEOUT_CYCLES - 1);
   localparam logic [23:0] TmoMax   = '1;

   typedef enum logic [2:0] {
      StIdle,
      StWaitCts,
      StSend,
      StWaitEcho,
      StRecv,
      StDone
   } state_e;

   state_e      state_q, state_d;
   logic        cts_s1_q, cts_s2_q;
   logic        rx_s1_q, rx_s2_q, rx_prev_q;
   logic        live_q;
   logic [7:0]  data_q, data_d;
   logic [15:0] clk_cnt_q, clk_cnt_d;
   logic [3:0]  bit_idx_q, bit_idx_d;
   logic [23:0] tmo_q, tmo_d;
   logic [23:0] tmo_inc;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  rsp_data_q, rsp_data_d;
   logic        rsp_match_q, rsp_match_d;
   logic        rsp_timeout_q, rsp_timeout_d;
   logic        rsp_frame_err_q, rsp_frame_err_d;
   logic [9:0]  frame;

   // Synchronizers; rx_prev_q provides the falling-edge reference for the start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cts_s1_q  <= 1'b0;
         cts_s2_q  <= 1'b0;
         rx_s1_q   <= 1'b1;
         rx_s2_q   <= 1'b1;
         rx_prev_q <= 1'b1;
         live_q    <= 1'b0;
      end else begin
         cts_s1_q  <= cts;
         cts_s2_q  <= cts_s1_q;
         rx_s1_q   <= rx;
         rx_s2_q   <= rx_s1_q;
         rx_prev_q <= rx_s2_q;
         live_q    <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= StIdle;
         data_q          <= 8'h00;
         clk_cnt_q       <= 16'd0;
         bit_idx_q       <= 4'd0;
         tmo_q           <= 24'd0;
         shift_q         <= 8'h00;
         rsp_data_q      <= 8'h00;
         rsp_match_q     <= 1'b0;
         rsp_timeout_q   <= 1'b0;
         rsp_frame_err_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         data_q          <= data_d;
         clk_cnt_q       <= clk_cnt_d;
         bit_idx_q       <= bit_idx_d;
         tmo_q           <= tmo_d;
         shift_q         <= shift_d;
         rsp_data_q      <= rsp_data_d;
         rsp_match_q     <= rsp_match_d;
         rsp_timeout_q   <= rsp_timeout_d;
         rsp_frame_err_q <= rsp_frame_err_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      data_d          = data_q;
      clk_cnt_d       = clk_cnt_q;
      bit_idx_d       = bit_idx_q;
      tmo_d           = tmo_q;
      shift_d         = shift_q;
      rsp_data_d      = rsp_data_q;
      rsp_match_d     = rsp_match_q;
      rsp_timeout_d   = rsp_timeout_q;
      rsp_frame_err_d = rsp_frame_err_q;
      tmo_inc         = (tmo_q == TmoMax) ? tmo_q : tmo_q + 24'd1;

      unique case (state_q)
         StIdle: begin
            if (req_valid && req_ready) begin
               data_d          = req_data;
               tmo_d           = 24'd0;
               clk_cnt_d       = 16'd0;
               bit_idx_d       = 4'd0;
               rsp_data_d      = 8'h00;
               rsp_match_d     = 1'b0;
               rsp_timeout_d   = 1'b0;
               rsp_frame_err_d = 1'b0;
               state_d         = StWaitCts;
            end
         end
         StWaitCts: begin
            if (cts_s2_q) begin
               state_d = StSend;
            end else if (tmo_q >= TmoLast) begin
               rsp_timeout_d = 1'b1;
               state_d       = StDone;
            end else begin
               tmo_d = tmo_inc;
            end
         end
         StSend: begin
            if (clk_cnt_q == BitLast) begin
               clk_cnt_d = 16'd0;
               if (bit_idx_q == 4'd9) begin
                  bit_idx_d = 4'd0;
                  tmo_d     = 24'd0;
                  state_d   = StWaitEcho;
               end else begin
                  bit_idx_d = bit_idx_q + 4'd1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 16'd1;
            end
         end
         StWaitEcho: begin
            if (rx_prev_q && !rx_s2_q) begin
               clk_cnt_d = 16'd0;
               bit_idx_d = 4'd0;
               state_d   = StRecv;
            end else if (tmo_q >= TmoLast) begin
               rsp_timeout_d = 1'b1;
               state_d       = StDone;
            end else begin
               tmo_d = tmo_inc;
            end
         end
         StRecv: begin
            // Keep timing the echo so a run of glitches cannot hold off the timeout forever.
            tmo_d = tmo_inc;
            if (bit_idx_q == 4'd0) begin
               if (clk_cnt_q == HalfLast) begin
                  clk_cnt_d = 16'd0;
                  if (rx_s2_q) begin
                     state_d = StWaitEcho;
                  end else begin
                     bit_idx_d = 4'd1;
                  end
               end else begin
                  clk_cnt_d = clk_cnt_q + 16'd1;
               end
            end else if (clk_cnt_q == BitLast) begin
               clk_cnt_d = 16'd0;
               if (bit_idx_q == 4'd9) begin
                  bit_idx_d       = 4'd0;
                  rsp_data_d      = shift_q;
                  rsp_frame_err_d = !rx_s2_q;
                  rsp_match_d     = rx_s2_q && (shift_q == data_q);
                  state_d         = StDone;
               end else begin
                  shift_d   = {rx_s2_q, shift_q[7:1]};
                  bit_idx_d = bit_idx_q + 4'd1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + 16'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Decoded from state so reset forces the line idle without waiting for a clock.
   assign frame         = {1'b1, data_q, 1'b0};
   assign tx            = (state_q == StSend) ? frame[bit_idx_q] : 1'b1;
   assign rts           = (state_q == StWaitCts) || (state_q == StSend);
   assign req_ready     = live_q && (state_q == StIdle);
   assign rsp_valid     = (state_q == StDone);
   assign rsp_data      = rsp_data_q;
   assign rsp_match     = rsp_match_q;
   assign rsp_timeout   = rsp_timeout_q;
   assign rsp_frame_err = rsp_frame_err_q;

endmodule

// File: tb/tb_uart_host_link.sv
// Directed bench for uart_host_link at 4 clocks per bit and a 64-cycle timeout.
`timescale 1ns / 1ps

module tb_uart_host_link;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req_data;
   logic       req_valid;
   logic       req_ready;
   logic       rts;
   logic       cts;
   logic       tx;
   logic       rx;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_match;
   logic       rsp_timeout;
   logic       rsp_frame_err;

   int checks = 0;
   int errors = 0;

   uart_host_link #(
      .CLKS_PER_BIT  (4),
      .TIMEOUT_CYCLES(64)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_data     (req_data),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .rts          (rts),
      .cts          (cts),
      .tx           (tx),
      .rx           (rx),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .rsp_match    (rsp_match),
      .rsp_timeout  (rsp_timeout),
      .rsp_frame_err(rsp_frame_err)
   );

   always #5 clk = ~clk;

   // Wire sequence (index 0 first on the line) stretched to 4 samples per bit.
   function automatic logic [39:0] expand(input logic [9:0] seq);
      logic [39:0] r;
      for (int i = 0; i < 40; i++) r[i] = seq[i / 4];
      return r;
   endfunction

   task automatic issue(input logic [7:0] d);
      @(negedge clk);
      req_data  = d;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic grant_cts(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
         if (rts === 1'b1) ok = 1'b1;
         else @(negedge clk);
      end
      if (ok) begin
         @(negedge clk);
         cts = 1'b1;
      end
   endtask

   task automatic capture_frame(output logic [39:0] bits, output bit found, output bit rts_ok);
      found  = 1'b0;
      rts_ok = 1'b1;
      bits   = '1;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (tx === 1'b0) found = 1'b1;
      end
      if (found) begin
         bits[0] = tx;
         rts_ok  = (rts === 1'b1);
         for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            bits[i] = tx;
            if (rts !== 1'b1) rts_ok = 1'b0;
         end
      end
   endtask

   task automatic drive_echo(input logic [7:0] d, input logic stop);
      logic [9:0] fr;
      fr = {stop, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = fr[i];
         repeat (4) @(negedge clk);
      end
      rx = 1'b1;
   endtask

   task automatic watch_rsp(input int cycles, output int n, output logic [7:0] d,
                            output logic m, output logic t, output logic f);
      n = 0;
      d = 8'hxx;
      m = 1'bx;
      t = 1'bx;
      f = 1'bx;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin
            if (n == 0) begin
               d = rsp_data;
               m = rsp_match;
               t = rsp_timeout;
               f = rsp_frame_err;
            end
            n++;
         end
      end
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_data  = 8'h00;
      cts       = 1'b0;
      rx        = 1'b1;
      #12;
      checks++;
      if (tx !== 1'b1 || rts !== 1'b0) begin
         errors++;
         $display("FAIL reset_lines: tx=%b rts=%b expected tx=1 rts=0", tx, rts);
      end
      checks++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_hs: req_ready=%b rsp_valid=%b expected 0 0", req_ready, rsp_valid);
      end
      checks++;
      if ({rsp_data, rsp_match, rsp_timeout, rsp_frame_err} !== 11'd0) begin
         errors++;
         $display("FAIL reset_rsp: data=%h m=%b t=%b f=%b expected all 0", rsp_data, rsp_match,
                  rsp_timeout, rsp_frame_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_before_edge: got %b expected 0", req_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_edge: got %b expected 1", req_ready);
      end
   endtask

   task automatic test_loopback;
      bit ok, found, rts_ok;
      logic [39:0] bits;
      int n;
      logic [7:0] d;
      logic m, t, f;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL lb_ready: got %b expected 1", req_ready);
      end
      issue(8'hA5);
      grant_cts(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL lb_rts: rts never rose (got 0 expected 1)");
      end
      capture_frame(bits, found, rts_ok);
      checks++;
      // 0,1,0,1,0,0,1,0,1,1 on the wire
      if (!found || bits !== expand(10'b11_0100_1010)) begin
         errors++;
         $display("FAIL lb_tx_frame: got %b expected %b", bits, expand(10'b11_0100_1010));
      end
      checks++;
      if (!rts_ok) begin
         errors++;
         $display("FAIL lb_rts_during_send: got dropout expected rts=1");
      end
      @(negedge clk);
      cts = 1'b0;
      checks++;
      if (tx !== 1'b1 || rts !== 1'b0) begin
         errors++;
         $display("FAIL lb_after_frame: tx=%b rts=%b expected 1 0", tx, rts);
      end
      fork
         drive_echo(8'hA5, 1'b1);
         watch_rsp(60, n, d, m, t, f);
      join
      checks++;
      if (n != 1) begin
         errors++;
         $display("FAIL lb_pulses: got %0d expected 1", n);
      end
      checks++;
      if (d !== 8'hA5 || m !== 1'b1 || t !== 1'b0 || f !== 1'b0) begin
         errors++;
         $display("FAIL lb_rsp: data=%h m=%b t=%b f=%b expected a5 1 0 0", d, m, t, f);
      end
      checks++;
      if (rsp_data !== 8'hA5 || rsp_match !== 1'b1) begin
         errors++;
         $display("FAIL lb_hold: data=%h m=%b expected a5 1", rsp_data, rsp_match);
      end
   endtask

   task automatic test_cts_timeout;
      int done_at;
      bit tx_ok, rts_ok;
      done_at = -1;
      tx_ok   = 1'b1;
      rts_ok  = 1'b1;
      issue(8'h77);
      // Now at the first negedge after the accepting edge (n = 1).
      for (int nn = 1; nn <= 100 && done_at < 0; nn++) begin
         if (nn > 1) @(negedge clk);
         if (tx !== 1'b1) tx_ok = 1'b0;
         if (rsp_valid === 1'b1) done_at = nn;
         else if (rts !== 1'b1) rts_ok = 1'b0;
      end
      checks++;
      if (done_at != 65) begin
         errors++;
         $display("FAIL tmo_latency: done at n=%0d expected 65", done_at);
      end
      checks++;
      if (!tx_ok || !rts_ok) begin
         errors++;
         $display("FAIL tmo_lines: tx_ok=%b rts_ok=%b expected 1 1", tx_ok, rts_ok);
      end
      checks++;
      if (rsp_timeout !== 1'b1 || rsp_match !== 1'b0 || rsp_frame_err !== 1'b0 ||
          rsp_data !== 8'h00) begin
         errors++;
         $display("FAIL tmo_rsp: t=%b m=%b f=%b data=%h expected 1 0 0 00", rsp_timeout,
                  rsp_match, rsp_frame_err, rsp_data);
      end
      @(negedge clk);
      checks++;
      if (rts !== 1'b0 || rsp_timeout !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL tmo_after: rts=%b t=%b v=%b rdy=%b expected 0 1 0 1", rts, rsp_timeout,
                  rsp_valid, req_ready);
      end
   endtask

   task automatic test_wrong_echo;
      bit ok, found, rts_ok;
      logic [39:0] bits;
      int n;
      logic [7:0] d;
      logic m, t, f;
      issue(8'h3C);
      checks++;
      if (rsp_timeout !== 1'b0) begin
         errors++;
         $display("FAIL we_clear: rsp_timeout=%b expected 0", rsp_timeout);
      end
      grant_cts(ok);
      capture_frame(bits, found, rts_ok);
      checks++;
      if (!ok || !found || bits !== expand({1'b1, 8'h3C, 1'b0})) begin
         errors++;
         $display("FAIL we_tx_frame: got %b expected %b", bits, expand({1'b1, 8'h3C, 1'b0}));
      end
      @(negedge clk);
      cts = 1'b0;
      fork
         drive_echo(8'h3D, 1'b1);
         watch_rsp(60, n, d, m, t, f);
      join
      checks++;
      if (n != 1 || d !== 8'h3D || m !== 1'b0 || f !== 1'b0 || t !== 1'b0) begin
         errors++;
         $display("FAIL we_rsp: n=%0d data=%h m=%b f=%b t=%b expected 1 3d 0 0 0", n, d, m, f, t);
      end
   endtask

   task automatic test_frame_err;
      bit ok, found, rts_ok;
      logic [39:0] bits;
      int n;
      logic [7:0] d;
      logic m, t, f;
      issue(8'h5A);
      grant_cts(ok);
      capture_frame(bits, found, rts_ok);
      @(negedge clk);
      cts = 1'b0;
      fork
         drive_echo(8'h5A, 1'b0);
         watch_rsp(60, n, d, m, t, f);
      join
      checks++;
      if (n != 1 || f !== 1'b1 || m !== 1'b0 || d !== 8'h5A || t !== 1'b0) begin
         errors++;
         $display("FAIL fe_rsp: n=%0d f=%b m=%b data=%h t=%b expected 1 1 0 5a 0", n, f, m, d, t);
      end
   endtask

   task automatic test_robustness;
      bit ok, found, rdy_ok;
      logic [39:0] bits;
      int n;
      logic [7:0] d;
      logic m, t, f;
      issue(8'h96);
      grant_cts(ok);
      found  = 1'b0;
      rdy_ok = 1'b1;
      bits   = '1;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (tx === 1'b0) found = 1'b1;
      end
      if (found) begin
         for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            bits[i] = tx;
            if (req_ready !== 1'b0) rdy_ok = 1'b0;
            if (i == 0) begin
               req_valid = 1'b1;
               req_data  = 8'hFF;
            end
            if (i == 12) cts = 1'b0;
         end
         req_valid = 1'b0;
      end
      checks++;
      if (!found || bits !== expand({1'b1, 8'h96, 1'b0})) begin
         errors++;
         $display("FAIL rb_tx_frame: got %b expected %b", bits, expand({1'b1, 8'h96, 1'b0}));
      end
      checks++;
      if (!rdy_ok) begin
         errors++;
         $display("FAIL rb_ready_in_send: got 1 expected 0");
      end
      @(negedge clk);
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      watch_rsp(8, n, d, m, t, f);
      checks++;
      if (n != 0) begin
         errors++;
         $display("FAIL rb_glitch: got %0d pulses expected 0", n);
      end
      fork
         drive_echo(8'h96, 1'b1);
         watch_rsp(60, n, d, m, t, f);
      join
      checks++;
      if (n != 1 || d !== 8'h96 || m !== 1'b1 || t !== 1'b0) begin
         errors++;
         $display("FAIL rb_rsp: n=%0d data=%h m=%b t=%b expected 1 96 1 0", n, d, m, t);
      end
   endtask

   task automatic test_reset_mid_send;
      bit ok, found, rts_ok;
      logic [39:0] bits;
      int n;
      logic [7:0] d;
      logic m, t, f;
      issue(8'h81);
      grant_cts(ok);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (tx === 1'b0) found = 1'b1;
      end
      repeat (12) @(negedge clk);
      checks++;
      if (!found || tx !== 1'b0 || rts !== 1'b1) begin
         errors++;
         $display("FAIL rm_bit3: tx=%b rts=%b expected 0 1", tx, rts);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (tx !== 1'b1 || rts !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rm_async: tx=%b rts=%b rdy=%b v=%b expected 1 0 0 0", tx, rts, req_ready,
                  rsp_valid);
      end
      checks++;
      if (rsp_data !== 8'h00 || rsp_match !== 1'b0) begin
         errors++;
         $display("FAIL rm_rsp_clear: data=%h m=%b expected 00 0", rsp_data, rsp_match);
      end
      cts = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL rm_ready_before_edge: got %b expected 0", req_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL rm_ready_after_edge: rdy=%b v=%b expected 1 0", req_ready, rsp_valid);
      end
      issue(8'h81);
      grant_cts(ok);
      capture_frame(bits, found, rts_ok);
      checks++;
      if (!ok || !found || bits !== expand({1'b1, 8'h81, 1'b0})) begin
         errors++;
         $display("FAIL rm_tx_frame: got %b expected %b", bits, expand({1'b1, 8'h81, 1'b0}));
      end
      @(negedge clk);
      cts = 1'b0;
      fork
         drive_echo(8'h81, 1'b1);
         watch_rsp(60, n, d, m, t, f);
      join
      checks++;
      if (n != 1 || d !== 8'h81 || m !== 1'b1 || f !== 1'b0) begin
         errors++;
         $display("FAIL rm_rsp: n=%0d data=%h m=%b f=%b expected 1 81 1 0", n, d, m, f);
      end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_cts_timeout();
      test_wrong_echo();
      test_frame_err();
      test_robustness();
      test_reset_mid_send();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
